// File: rtl/pdm_tone_pkg.sv
// Shared types and elaboration-time helpers for the PDM tone source.
// The sine table is computed here so the top can fold it into constants.
package pdm_tone_pkg;

   typedef enum logic [1:0] {
      MODE_SILENT = 2'd0,
      MODE_SINE   = 2'd1,
      MODE_DC     = 2'd2,
      MODE_SQUARE = 2'd3
   } mode_t;

   localparam real PI = 3.14159265358979323846;

   // Full-wave sine entry scaled to +/-(2**(data_w-1)-1), rounded half away from zero.
   function automatic int sine_lut(input int addr, input int lut_aw, input int data_w);
      real amp;
      real x;
      amp = real'((1 << (data_w - 1)) - 1);
      x   = amp * $sin(2.0 * PI * real'(addr) / real'(1 << lut_aw));
      if (x >= 0.0) begin
         return int'($floor(x + 0.5));
      end
      return -int'($floor(-x + 0.5));
   endfunction

endpackage

// File: rtl/pdm_sd_mod.sv
// First-order sigma-delta modulator: the carry of acc + sample is the PDM bit,
// so the ones density equals sample / 2**DATA_W.
module pdm_sd_mod
   import pdm_tone_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              en,
   input  logic [DATA_W-1:0] sample,
   output logic              pdm_bit
);

   logic [DATA_W-1:0] acc_q, acc_d;
   logic              bit_q, bit_d;
   logic [DATA_W:0]   sum;

   always_comb begin
      sum   = {1'b0, acc_q} + {1'b0, sample};
      acc_d = acc_q;
      bit_d = bit_q;
      if (clr) begin
         acc_d = '0;
         bit_d = 1'b0;
      end else if (en) begin
         acc_d = sum[DATA_W-1:0];
         bit_d = sum[DATA_W];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         bit_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         bit_q <= bit_d;
      end
   end

   assign pdm_bit = bit_q;

endmodule

// File: rtl/pdm_tone_source.sv
// Stereo PDM microphone model: m_clk divider, per-channel tone source
// (sine/DC/square/silent) feeding a sigma-delta modulator, interleaved onto m_data.
module pdm_tone_source
   import pdm_tone_pkg::*;
#(
   parameter int CLK_DIV = 40,
   parameter int NUM_CH  = 2,
   parameter int DATA_W  = 16,
   parameter int PHASE_W = 16,
   parameter int LUT_AW  = 7
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      enable,
   input  mode_t                     mode,
   input  logic [NUM_CH*PHASE_W-1:0] tone_step,
   input  logic [NUM_CH*4-1:0]       amp_shift,
   input  logic [DATA_W-1:0]         dc_level,
   output logic                      m_clk,
   output logic                      m_data,
   output logic [NUM_CH-1:0]         pdm_bits,
   output logic                      tick
);

   localparam int DIV_W = $clog2(CLK_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
   localparam logic [DATA_W-1:0] MIDSCALE = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic signed [DATA_W-1:0] POS_MAX = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic signed [DATA_W-1:0] NEG_MAX = {1'b1, {(DATA_W-2){1'b0}}, 1'b1};

   logic [DIV_W-1:0]  div_q, div_d;
   logic              m_clk_q, m_clk_d;
   logic              m_data_q, m_data_d;
   logic              tick_q, tick_d;
   logic              upd;
   logic              low_bit;
   logic [NUM_CH-1:0] pdm_bits_w;

   logic signed [DATA_W-1:0] sine_rom [2**LUT_AW];

   for (genvar i = 0; i < 2**LUT_AW; i++) begin : g_rom
      localparam logic signed [DATA_W-1:0] ROM_VAL = DATA_W'(sine_lut(i, LUT_AW, DATA_W));
      assign sine_rom[i] = ROM_VAL;
   end

   // m_clk and tick are registered from div_q, so each lags the count by one cycle;
   // tone state advances on the same edge that raises tick.
   always_comb begin
      div_d   = '0;
      m_clk_d = 1'b0;
      tick_d  = 1'b0;
      if (enable) begin
         div_d   = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
         m_clk_d = (div_q < DIV_HALF);
         tick_d  = (div_q == DIV_LAST);
      end
   end

   assign upd = tick_d;

   if (NUM_CH > 1) begin : g_stereo
      assign low_bit = pdm_bits_w[1];
   end else begin : g_mono
      assign low_bit = pdm_bits_w[0];
   end

   // Modulator bits change on the tick edge while m_clk is low, so m_data only
   // picks them up at the next m_clk edge.
   always_comb begin
      m_data_d = 1'b0;
      if (enable) begin
         m_data_d = m_clk_d ? pdm_bits_w[0] : low_bit;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q    <= '0;
         m_clk_q  <= 1'b0;
         m_data_q <= 1'b0;
         tick_q   <= 1'b0;
      end else begin
         div_q    <= div_d;
         m_clk_q  <= m_clk_d;
         m_data_q <= m_data_d;
         tick_q   <= tick_d;
      end
   end

   for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
      logic [PHASE_W-1:0]       phase_q, phase_d;
      logic [DATA_W-1:0]        sample_q, sample_d;
      logic [3:0]               shamt;
      logic signed [DATA_W-1:0] wave;
      logic signed [DATA_W-1:0] shaped;

      assign shamt = amp_shift[ch*4 +: 4];

      always_comb begin
         wave     = (mode == MODE_SQUARE) ? (phase_q[PHASE_W-1] ? NEG_MAX : POS_MAX)
                                          : sine_rom[phase_q[PHASE_W-1 -: LUT_AW]];
         shaped   = wave >>> shamt;
         phase_d  = phase_q;
         sample_d = sample_q;
         if (!enable) begin
            phase_d  = '0;
            sample_d = '0;
         end else if (upd) begin
            phase_d = phase_q + tone_step[ch*PHASE_W +: PHASE_W];
            case (mode)
               MODE_SILENT: sample_d = MIDSCALE;
               MODE_DC:     sample_d = dc_level;
               default:     sample_d = {~shaped[DATA_W-1], shaped[DATA_W-2:0]};
            endcase
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            phase_q  <= '0;
            sample_q <= '0;
         end else begin
            phase_q  <= phase_d;
            sample_q <= sample_d;
         end
      end

      pdm_sd_mod #(
         .DATA_W (DATA_W)
      ) u_sd (
         .clk     (clk),
         .rst_n   (rst_n),
         .clr     (~enable),
         .en      (upd),
         .sample  (sample_q),
         .pdm_bit (pdm_bits_w[ch])
      );
   end

   assign m_clk    = m_clk_q;
   assign m_data   = m_data_q;
   assign tick     = tick_q;
   assign pdm_bits = pdm_bits_w;

endmodule

// File: tb/tb_pdm_tone_source.sv
// Bench for pdm_tone_source: a tick-level tone/sigma-delta model pushes expected
// bit pairs to a queue, popped and compared whenever the DUT ticks.
module tb_pdm_tone_source;
   import pdm_tone_pkg::*;

   localparam int CLK_DIV = 40;

   logic        clk       = 1'b0;
   logic        rst_n     = 1'b0;
   logic        enable    = 1'b0;
   mode_t       mode      = MODE_SILENT;
   logic [31:0] tone_step = '0;
   logic [7:0]  amp_shift = '0;
   logic [15:0] dc_level  = '0;
   logic        m_clk;
   logic        m_data;
   logic [1:0]  pdm_bits;
   logic        tick;

   int n_cmp = 0;
   int n_bad = 0;

   logic [1:0] exp_q[$];
   logic [1:0] bit_log[$];
   logic [1:0] rec[32];
   int         m_phase[2];
   int         m_sample[2];
   int         m_acc[2];
   logic [1:0] exp_b;
   int         pos;
   int         tick_cnt;
   logic       chk_m;

   always #5 clk = ~clk;

   pdm_tone_source #(
      .CLK_DIV (CLK_DIV),
      .NUM_CH  (2),
      .DATA_W  (16),
      .PHASE_W (16),
      .LUT_AW  (7)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .mode      (mode),
      .tone_step (tone_step),
      .amp_shift (amp_shift),
      .dc_level  (dc_level),
      .m_clk     (m_clk),
      .m_data    (m_data),
      .pdm_bits  (pdm_bits),
      .tick      (tick)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int model_sample(input int ch);
      int  v;
      int  sh;
      real x;
      sh = int'(amp_shift[ch*4 +: 4]);
      if (mode == MODE_SILENT) return 32768;
      if (mode == MODE_DC) return int'(dc_level);
      if (mode == MODE_SINE) begin
         x = 32767.0 * $sin(2.0 * 3.14159265358979 * real'(m_phase[ch] >> 9) / 128.0);
         v = (x >= 0.0) ? int'($floor(x + 0.5)) : -int'($floor(-x + 0.5));
      end else begin
         v = (((m_phase[ch] >> 15) & 1) == 1) ? -32767 : 32767;
      end
      v = v >>> sh;
      return (v & 32'hFFFF) ^ 32'h8000;
   endfunction

   task automatic model_tick();
      for (int ch = 0; ch < 2; ch++) begin
         int s;
         s            = m_acc[ch] + m_sample[ch];
         exp_b[ch]    = (s >= 65536);
         m_acc[ch]    = s & 32'hFFFF;
         m_sample[ch] = model_sample(ch);
         m_phase[ch]  = (m_phase[ch] + int'(tone_step[ch*16 +: 16])) & 32'hFFFF;
      end
      exp_q.push_back(exp_b);
   endtask

   task automatic model_clear();
      for (int ch = 0; ch < 2; ch++) begin
         m_phase[ch]  = 0;
         m_sample[ch] = 0;
         m_acc[ch]    = 0;
      end
      exp_b = 2'b00;
      exp_q.delete();
   endtask

   task automatic step_clk();
      logic [1:0] e;
      @(negedge clk);
      pos++;
      if (tick) begin
         check("tick_pos", pos, CLK_DIV);
         model_tick();
         e = exp_q.pop_front();
         check("pdm_bits", 32'(pdm_bits), 32'(e));
         bit_log.push_back(pdm_bits);
         pos = 0;
         tick_cnt++;
      end
      if (chk_m && pos == 10) begin
         check("m_clk_hi", 32'(m_clk), 1);
         check("m_data_ch0", 32'(m_data), 32'(exp_b[0]));
      end
      if (chk_m && pos == 30) begin
         check("m_clk_lo", 32'(m_clk), 0);
         check("m_data_ch1", 32'(m_data), 32'(exp_b[1]));
      end
   endtask

   task automatic run_ticks(input int n);
      int target;
      int budget;
      target = tick_cnt + n;
      budget = n * CLK_DIV + 100;
      while (tick_cnt < target && budget > 0) begin
         step_clk();
         budget--;
      end
      if (tick_cnt < target) check("tick_timeout", tick_cnt, target);
   endtask

   task automatic start_run();
      model_clear();
      bit_log.delete();
      tick_cnt = 0;
      pos      = 0;
      chk_m    = 1'b1;
      enable   = 1'b1;
   endtask

   task automatic stop_run();
      enable = 1'b0;
      chk_m  = 1'b0;
      step_clk();
      model_clear();
   endtask

   task automatic idle_quiet(input string tag, input int cycles);
      int active;
      active = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (m_clk || m_data || tick || (pdm_bits != 2'b00)) active++;
      end
      check(tag, active, 0);
   endtask

   initial begin
      int         first_tick_at;
      int         hi_cnt;
      int         ones;
      int         ones_b;
      int         diffs;
      logic [7:0] pat;

      chk_m = 1'b0;
      model_clear();

      // Power-on reset, then released with enable low.
      repeat (3) @(negedge clk);
      check("por_outputs", {m_clk, m_data, tick, pdm_bits}, 0);
      rst_n = 1'b1;
      idle_quiet("idle_after_por", 50);

      // DC 25%: first enabled period also exercises the divider timing.
      mode     = MODE_DC;
      dc_level = 16'h4000;
      start_run();
      first_tick_at = 0;
      hi_cnt        = 0;
      for (int i = 1; i <= CLK_DIV; i++) begin
         step_clk();
         if (i == 1) check("m_clk_first", 32'(m_clk), 1);
         if (m_clk) hi_cnt++;
         if (tick && first_tick_at == 0) first_tick_at = i;
      end
      check("m_clk_hi_cnt", hi_cnt, CLK_DIV / 2);
      check("first_tick_at", first_tick_at, CLK_DIV);
      run_ticks(40);
      pat = '0;
      for (int k = 1; k <= 4; k++) pat = {pat[6:0], bit_log[k][0]};
      check("dc_pattern", 32'(pat[3:0]), 32'h1);
      ones = 0;
      for (int k = 1; k <= 40; k++) ones += int'(bit_log[k][0]);
      check("dc_density", ones, 10);

      // Silent: alternating bits from the second tick.
      stop_run();
      mode = MODE_SILENT;
      start_run();
      run_ticks(9);
      pat = '0;
      for (int k = 1; k <= 8; k++) pat = {pat[6:0], bit_log[k][0]};
      check("silent_pattern", 32'(pat), 32'h55);

      // Full-scale sine on ch0, faster attenuated sine on ch1.
      stop_run();
      mode      = MODE_SINE;
      tone_step = {16'd1536, 16'd512};
      amp_shift = {4'd2, 4'd0};
      start_run();
      run_ticks(129);
      ones   = 0;
      ones_b = 0;
      for (int k = 1; k <= 64; k++) ones += int'(bit_log[k][0]);
      for (int k = 65; k <= 128; k++) ones_b += int'(bit_log[k][0]);
      check("sine_ones_in_range", 32'((ones + ones_b) >= 63 && (ones + ones_b) <= 65), 1);
      check("sine_half_order", 32'(ones > ones_b), 1);
      for (int k = 0; k < 32; k++) rec[k] = bit_log[k];

      // Drop enable mid-period, then restart and expect the same bitstream.
      repeat (10) step_clk();
      check("drop_pos", pos, 10);
      enable = 1'b0;
      chk_m  = 1'b0;
      @(negedge clk);
      check("drop_outputs", {m_clk, m_data, tick, pdm_bits}, 0);
      idle_quiet("idle_after_drop", 60);
      start_run();
      run_ticks(32);
      diffs = 0;
      for (int k = 0; k < 32; k++) if (bit_log[k] !== rec[k]) diffs++;
      check("rerun_diffs", diffs, 0);

      // Maximum attenuation collapses the sine to about midscale.
      stop_run();
      amp_shift = {4'd15, 4'd15};
      start_run();
      run_ticks(129);
      ones = 0;
      for (int k = 1; k <= 128; k++) ones += int'(bit_log[k][0]);
      check("sine_a15_in_range", 32'(ones >= 63 && ones <= 65), 1);

      // Square, then a live mode change to exercise the two-tick latency.
      stop_run();
      mode      = MODE_SQUARE;
      tone_step = {16'd4096, 16'd1024};
      amp_shift = {4'd15, 4'd1};
      start_run();
      run_ticks(30);
      mode     = MODE_DC;
      dc_level = 16'hC000;
      run_ticks(20);
      tone_step = {16'd700, 16'd300};
      amp_shift = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
      mode      = MODE_SINE;
      run_ticks(20);

      // Asynchronous reset while running, with m_clk high.
      repeat (5) step_clk();
      check("pre_reset_m_clk", 32'(m_clk), 1);
      #2 rst_n = 1'b0;
      #1 check("async_reset_outputs", {m_clk, m_data, tick, pdm_bits}, 0);
      enable = 1'b0;
      chk_m  = 1'b0;
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
      idle_quiet("idle_after_reset", 60);

      check("exp_q_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
